// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: computes a - b LSB first through one
// full-subtractor cell and a borrow flop, with a start/busy/done handshake.
module serial_subtractor #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-1:0] res;
    logic             br;
    logic [CW-1:0]    cnt;
    logic             d;
    logic             br_nxt;
    logic             last;

    // Full-subtractor cell on the current LSBs of the operand shifters
    always_comb begin
        d      = sa[0] ^ sb[0] ^ br;
        br_nxt = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & br);
        last   = (cnt == CW'(WIDTH - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                busy = 1'b1;
                if (last) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sa   <= '0;
            sb   <= '0;
            res  <= '0;
            br   <= 1'b0;
            cnt  <= '0;
            diff <= '0;
            bout <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        sa  <= a;
                        sb  <= b;
                        br  <= 1'b0;
                        cnt <= '0;
                    end
                end
                S_RUN: begin
                    res <= {d, res[WIDTH-1:1]};
                    sa  <= sa >> 1;
                    sb  <= sb >> 1;
                    br  <= br_nxt;
                    cnt <= cnt + CW'(1);
                    // Final bit goes straight to the output alongside the shifted partial result
                    if (last) begin
                        diff <= {d, res[WIDTH-1:1]};
                        bout <= br_nxt;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
